// File: rtl/vec_dispatch_buffer.sv
// Speculative dispatch queue between issue and the vector unit: entries are pushed at issue,
// committed in order, and only committed entries are presented for popping.
module vec_dispatch_buffer #(
    parameter int unsigned Depth        = 4,
    parameter int unsigned TransIdWidth = 3,
    parameter int unsigned XLEN         = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [31:0]             req_instr_i,
    input  logic [XLEN-1:0]         req_rs1_i,
    input  logic [XLEN-1:0]         req_rs2_i,
    input  logic [TransIdWidth-1:0] req_trans_id_i,
    input  logic                    commit_valid_i,
    input  logic [TransIdWidth-1:0] commit_trans_id_i,
    output logic                    commit_error_o,
    output logic                    vec_valid_o,
    input  logic                    vec_ready_i,
    output logic [31:0]             vec_instr_o,
    output logic [XLEN-1:0]         vec_rs1_o,
    output logic [XLEN-1:0]         vec_rs2_o,
    output logic [TransIdWidth-1:0] vec_trans_id_o,
    output logic [$clog2(Depth):0]  committed_cnt_o,
    output logic                    empty_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;
    localparam logic [PtrW-1:0] DepthP = PtrW'(Depth);

    logic [31:0]             instr_q [Depth];
    logic [XLEN-1:0]         rs1_q   [Depth];
    logic [XLEN-1:0]         rs2_q   [Depth];
    logic [TransIdWidth-1:0] id_q    [Depth];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] cptr_q, cptr_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic            commit_error_q, commit_error_d;

    logic [PtrW-1:0] total, uncommitted;
    logic            full, push, pop, commit_ok;

    always_comb begin
        total           = tail_q - head_q;
        uncommitted     = tail_q - cptr_q;
        committed_cnt_o = cptr_q - head_q;
        full            = (total == DepthP);
        empty_o         = (total == '0);
        vec_valid_o     = (committed_cnt_o != '0);
        req_ready_o     = rst_ni & ~flush_i & ~full;

        push      = req_valid_i & req_ready_o;
        pop       = vec_valid_o & vec_ready_i;
        commit_ok = commit_valid_i & (uncommitted != '0)
                  & (id_q[cptr_q[IdxW-1:0]] == commit_trans_id_i);

        head_d = head_q + PtrW'(pop);
        cptr_d = cptr_q + PtrW'(commit_ok);
        // Flush trims back to the commit pointer including this cycle's commit.
        tail_d = flush_i ? cptr_d : tail_q + PtrW'(push);

        commit_error_d = commit_valid_i & ~commit_ok;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q         <= '0;
            cptr_q         <= '0;
            tail_q         <= '0;
            commit_error_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            cptr_q         <= cptr_d;
            tail_q         <= tail_d;
            commit_error_q <= commit_error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                instr_q[i] <= '0;
                rs1_q[i]   <= '0;
                rs2_q[i]   <= '0;
                id_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[tail_q[IdxW-1:0]] <= req_instr_i;
            rs1_q[tail_q[IdxW-1:0]]   <= req_rs1_i;
            rs2_q[tail_q[IdxW-1:0]]   <= req_rs2_i;
            id_q[tail_q[IdxW-1:0]]    <= req_trans_id_i;
        end
    end

    assign commit_error_o = commit_error_q;
    assign vec_instr_o    = instr_q[head_q[IdxW-1:0]];
    assign vec_rs1_o      = rs1_q[head_q[IdxW-1:0]];
    assign vec_rs2_o      = rs2_q[head_q[IdxW-1:0]];
    assign vec_trans_id_o = id_q[head_q[IdxW-1:0]];

endmodule

// File: tb/tb_vec_dispatch_buffer.sv
// Directed bench for vec_dispatch_buffer (Depth 4, 3-bit ids, XLEN 64).
module tb_vec_dispatch_buffer;

    logic        clk = 1'b0;
    logic        rst_n, flush, req_valid, req_ready;
    logic [31:0] req_instr;
    logic [63:0] req_rs1, req_rs2;
    logic [2:0]  req_id;
    logic        commit_valid, commit_error;
    logic [2:0]  commit_id;
    logic        vec_valid, vec_ready;
    logic [31:0] vec_instr;
    logic [63:0] vec_rs1, vec_rs2;
    logic [2:0]  vec_id;
    logic [2:0]  ccnt;
    logic        empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_dispatch_buffer #(.Depth(4), .TransIdWidth(3), .XLEN(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_instr_i(req_instr),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_trans_id_i(req_id),
        .commit_valid_i(commit_valid), .commit_trans_id_i(commit_id),
        .commit_error_o(commit_error), .vec_valid_o(vec_valid), .vec_ready_i(vec_ready),
        .vec_instr_o(vec_instr), .vec_rs1_o(vec_rs1), .vec_rs2_o(vec_rs2),
        .vec_trans_id_o(vec_id), .committed_cnt_o(ccnt), .empty_o(empty)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change #1 after an edge; checks happen 1ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; req_valid = 1'b0; commit_valid = 1'b0; vec_ready = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] ins, input logic [2:0] id);
        req_valid = 1'b1; req_instr = ins; req_id = id;
        req_rs1 = 64'(ins) + 64'h1000; req_rs2 = 64'(ins) + 64'h2000;
    endtask

    task automatic set_commit(input logic [2:0] id);
        commit_valid = 1'b1; commit_id = id;
    endtask

    logic [31:0] exp_q[$];
    int pushed, committed, popped, m_total, m_comm, cyc;
    logic do_push, do_commit, do_pop;

    initial begin
        rst_n = 1'b0; idle();
        req_instr = '0; req_rs1 = '0; req_rs2 = '0; req_id = '0; commit_id = '0;
        tick(); tick();
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_vvalid", 64'(vec_valid), 64'(0));
        chk("rst_cnt", 64'(ccnt), 64'(0));
        chk("rst_err", 64'(commit_error), 64'(0));
        chk("rst_instr", 64'(vec_instr), 64'(0));
        chk("rst_rs1", vec_rs1, 64'(0));
        rst_n = 1'b1; #1;
        chk("rel_ready", 64'(req_ready), 64'(1));

        // Basic flow
        tick();
        set_push(32'hA000_0001, 3'd1);
        tick();
        idle(); set_commit(3'd1); #1;
        chk("basic_vvalid_early", 64'(vec_valid), 64'(0));
        tick();
        idle(); vec_ready = 1'b1; #1;
        chk("basic_vvalid", 64'(vec_valid), 64'(1));
        chk("basic_instr", 64'(vec_instr), 64'h A000_0001);
        chk("basic_rs1", vec_rs1, 64'h A000_1001);
        chk("basic_rs2", vec_rs2, 64'h A000_2001);
        chk("basic_id", 64'(vec_id), 64'(1));
        chk("basic_cnt", 64'(ccnt), 64'(1));
        tick();
        idle(); #1;
        chk("basic_empty", 64'(empty), 64'(1));
        chk("basic_vvalid_after", 64'(vec_valid), 64'(0));

        // Fill with no commits
        for (int i = 0; i < 4; i++) begin
            set_push(32'h100 + 32'(i), 3'(i));
            tick();
        end
        idle(); #1;
        chk("fill_ready", 64'(req_ready), 64'(0));
        chk("fill_vvalid", 64'(vec_valid), 64'(0));
        chk("fill_empty", 64'(empty), 64'(0));
        set_commit(3'd0); tick();
        set_commit(3'd1); tick();
        idle(); #1;
        chk("fill_cnt2", 64'(ccnt), 64'(2));
        chk("fill_ready_full", 64'(req_ready), 64'(0));
        // Pop while full with a push offered: push must not be taken
        vec_ready = 1'b1; set_push(32'h1FF, 3'd7); #1;
        chk("fill_head", 64'(vec_instr), 64'h100);
        tick();
        idle(); #1;
        chk("fill_cnt1", 64'(ccnt), 64'(1));
        chk("fill_ready_after_pop", 64'(req_ready), 64'(1));
        chk("fill_head2", 64'(vec_instr), 64'h101);
        set_commit(3'd2); tick();
        set_commit(3'd3); tick();
        set_commit(3'd7); tick();
        idle(); #1;
        chk("fill_no_bypass_err", 64'(commit_error), 64'(1));
        chk("fill_cnt3", 64'(ccnt), 64'(3));
        for (int i = 1; i < 4; i++) begin
            vec_ready = 1'b1; #1;
            chk("fill_drain", 64'(vec_instr), 64'h100 + 64'(i));
            tick();
        end
        idle(); #1;
        chk("fill_drain_empty", 64'(empty), 64'(1));

        // Flush mix
        for (int i = 1; i <= 3; i++) begin
            set_push(32'h200 + 32'(i), 3'(i));
            tick();
        end
        idle(); set_commit(3'd1); tick();
        idle(); flush = 1'b1; set_commit(3'd2); set_push(32'h2FF, 3'd4); #1;
        chk("flush_ready", 64'(req_ready), 64'(0));
        tick();
        idle(); #1;
        chk("flush_cnt", 64'(ccnt), 64'(2));
        chk("flush_empty", 64'(empty), 64'(0));
        set_commit(3'd3); tick();
        idle(); #1;
        chk("flush_dropped_err", 64'(commit_error), 64'(1));
        for (int i = 1; i <= 2; i++) begin
            vec_ready = 1'b1; #1;
            chk("flush_drain", 64'(vec_instr), 64'h200 + 64'(i));
            tick();
        end
        idle(); #1;
        chk("flush_err_clear", 64'(commit_error), 64'(0));
        chk("flush_empty_end", 64'(empty), 64'(1));

        // Commit errors
        set_commit(3'd0); tick();
        idle(); #1;
        chk("cerr_empty", 64'(commit_error), 64'(1));
        chk("cerr_empty_cnt", 64'(ccnt), 64'(0));
        chk("cerr_empty_e", 64'(empty), 64'(1));
        tick();
        chk("cerr_pulse", 64'(commit_error), 64'(0));
        set_push(32'h305, 3'd5); tick();
        idle(); set_commit(3'd6); tick();
        idle(); #1;
        chk("cerr_mismatch", 64'(commit_error), 64'(1));
        chk("cerr_mismatch_cnt", 64'(ccnt), 64'(0));
        set_commit(3'd5); tick();
        idle(); #1;
        chk("cerr_ok", 64'(commit_error), 64'(0));
        chk("cerr_ok_cnt", 64'(ccnt), 64'(1));
        vec_ready = 1'b1; tick();
        idle(); set_push(32'h322, 3'd2); set_commit(3'd2); tick();
        idle(); #1;
        chk("cerr_same_cycle", 64'(commit_error), 64'(1));
        chk("cerr_same_cnt", 64'(ccnt), 64'(0));
        set_commit(3'd2); tick();
        idle(); #1;
        chk("cerr_same_late", 64'(ccnt), 64'(1));
        vec_ready = 1'b1; tick();
        idle(); #1;
        chk("cerr_empty_end", 64'(empty), 64'(1));

        // Wrap: 12 entries streamed with random pop back-pressure
        pushed = 0; committed = 0; popped = 0; m_total = 0; m_comm = 0; cyc = 0;
        exp_q.delete();
        while (popped < 12 && cyc < 200) begin
            idle();
            do_push   = (pushed < 12) && (m_total < 4);
            do_commit = (committed < pushed);
            do_pop    = ($urandom_range(0, 1) == 1) && (m_comm > 0);
            if (do_push) set_push(32'h400 + 32'(pushed), 3'(pushed % 8));
            if (do_commit) set_commit(3'(committed % 8));
            vec_ready = do_pop;
            #1;
            chk("wrap_ready", 64'(req_ready), 64'(m_total < 4));
            chk("wrap_vvalid", 64'(vec_valid), 64'(m_comm > 0));
            if (m_comm > 0) chk("wrap_instr", 64'(vec_instr), 64'(exp_q[0]));
            tick();
            chk("wrap_err", 64'(commit_error), 64'(0));
            if (do_push) begin exp_q.push_back(32'h400 + 32'(pushed)); pushed++; end
            if (do_commit) committed++;
            if (do_pop) begin void'(exp_q.pop_front()); popped++; end
            m_total = pushed - popped;
            m_comm  = committed - popped;
            cyc++;
        end
        chk("wrap_done", 64'(popped), 64'(12));
        idle(); #1;
        chk("wrap_empty", 64'(empty), 64'(1));

        // Mid-operation reset
        for (int i = 0; i < 3; i++) begin
            set_push(32'h500 + 32'(i), 3'(i));
            tick();
        end
        idle(); set_commit(3'd0); tick();
        idle(); rst_n = 1'b0; #1;
        chk("mrst_ready_low", 64'(req_ready), 64'(0));
        tick();
        rst_n = 1'b1; #1;
        chk("mrst_empty", 64'(empty), 64'(1));
        chk("mrst_vvalid", 64'(vec_valid), 64'(0));
        chk("mrst_cnt", 64'(ccnt), 64'(0));
        set_push(32'h555, 3'd3); tick();
        idle(); set_commit(3'd3); tick();
        idle(); #1;
        chk("mrst_vvalid2", 64'(vec_valid), 64'(1));
        chk("mrst_instr", 64'(vec_instr), 64'h555);
        vec_ready = 1'b1; tick();
        idle(); #1;
        chk("mrst_empty2", 64'(empty), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_dispatch_buffer.md
# vec_dispatch_buffer

Speculative dispatch queue between the CVA6 issue stage and the vector unit (RVV enabled). Issue pushes vector instructions with their scalar operands as they are issued; entries stay speculative until the commit stage acknowledges them in order. Only committed entries are presented to the vector unit. A flush discards every speculative entry and keeps committed ones.

## Interface
- Depth, 4, number of entries; power of two, ≥2
- TransIdWidth, 3, scoreboard transaction-id width (log2 of 8 scoreboard entries)
- XLEN, 64, scalar operand width
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous and active-low
- flush_i  in  1  drop all uncommitted entries
- req_valid_i  in  1  issue offers an instruction
- req_ready_o  out  1  buffer accepts; low when full, when flush_i=1, or while rst_ni=0
- req_instr_i  in  32  vector instruction word
- req_rs1_i / req_rs2_i  in  XLEN  scalar operands
- req_trans_id_i  in  TransIdWidth  scoreboard id
- commit_valid_i  in  1  commit of the oldest uncommitted entry
- commit_trans_id_i  in  TransIdWidth  id being committed
- commit_error_o  out  1  registered one-cycle pulse: commit ignored (no uncommitted entry, or id mismatch)
- vec_valid_o  out  1  committed head entry available
- vec_ready_i  in  1  vector unit accepts
- vec_instr_o / vec_rs1_o / vec_rs2_o / vec_trans_id_o  out  32/XLEN/XLEN/TransIdWidth  head entry fields
- committed_cnt_o  out  log2(Depth)+1  committed, not yet popped entries
- empty_o  out  1  no entries of any kind (for fence/WFI)

## Operation
- Three pointers, each log2(Depth)+1 bits (extra wrap bit): head (pop), cptr (next to commit), tail (push). Invariant head ≤ cptr ≤ tail in modular order.
- Counts: total = tail−head; committed_cnt_o = cptr−head; uncommitted = tail−cptr. Full when total = Depth; arithmetic is modulo 2·Depth.
- Push: req_valid_i & req_ready_o → write entry at tail, tail+1.
- Commit: commit_valid_i with uncommitted>0 and commit_trans_id_i = id stored at cptr → cptr+1. Otherwise cptr unchanged and commit_error_o=1 next cycle.
- Commit only sees entries stored before the current edge; a commit in the same cycle as the push of that entry is an error.
- Pop: vec_valid_o & vec_ready_i → head+1. vec_valid_o = committed_cnt_o≠0. Output fields are combinational reads of storage at head.
- Flush: tail ← cptr after that cycle's commit is applied. That is, a commit in the flush cycle survives. A pop in the flush cycle also completes normally. Pushes are blocked because req_ready_o=0.
- Push and pop in the same cycle, when not full, are both performed. A full buffer does not accept a push even if a pop occurs in the same cycle; there is no bypass.
- Reset (rst_ni=0 at an edge): all pointers 0, storage 0, commit_error_o 0. Any entries in flight are lost. Reset has priority over every other input.

## Timing
- Reset values: vec_valid_o 0, vec_* data 0, committed_cnt_o 0, empty_o 1, commit_error_o 0, req_ready_o 0 while rst_ni=0 and 1 after release.
- Push edge N, commit edge ≥N+1; vec_valid_o high in the cycle after the commit edge.
- Minimum push-to-vector-unit latency: 2 cycles.
- Throughput: 1 push, 1 commit and 1 pop per cycle, sustained.
- commit_error_o asserts the cycle after the offending commit, for one cycle.
- All outputs except vec_* data, which follow head, are functions of registers only. req_ready_o additionally depends on flush_i.

## Test plan
- Basic flow: push A(id 1), commit id 1 the next cycle, vec_ready_i=1. Expected: vec_valid_o rises 2 cycles after the push with vec_instr_o=A; then empty_o=1.
- Fill: Depth=4, push 4 with no commit. Expected: req_ready_o=0, vec_valid_o=0. Commit 2 and pop 1: committed_cnt_o=1 and req_ready_o=1.
- Flush mix: push ids 1–3, commit 1, then flush_i together with commit 2. Expected: ids 1 and 2 are retained, 3 is dropped, committed_cnt_o=2. A push during flush is not accepted.
- Commit errors: commit on an empty buffer → commit_error_o pulse, pointers unchanged. Push id 5 then commit id 6 → error pulse and id 5 stays uncommitted. Commit in the same cycle as the push → error.
- Wrap: 3·Depth back-to-back push/commit/pop with vec_ready_i toggling randomly. Expected: in-order output matching the pushed sequence and no lost or duplicated entries.
- Mid-operation reset: rst_ni=0 for 1 cycle with 3 entries present. Expected: empty_o=1, vec_valid_o=0, committed_cnt_o=0 on the following cycle; a new push works normally.
